// File: rtl/systolic_pkg.sv
// Shared defaults, stream FSM encoding and a width helper for the systolic result path.
// Combinational content only; no latency or backpressure of its own.
package systolic_pkg;

    localparam int RESULT_WIDTH_DEF = 16;
    localparam int M_DEF            = 8;
    localparam int P_DEF            = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_t;

    // Never returns 0, so index ports stay at least one bit wide for 1-row/1-column shapes.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

endpackage

// File: rtl/systolic_result_narrow.sv
// Combinational RESULT_WIDTH -> OUT_WIDTH element conversion, zero latency, no flow control.
// STREAM_SAT_EN selects signed saturation; otherwise the low OUT_WIDTH bits are kept.
module systolic_result_narrow #(
    parameter int RESULT_WIDTH = 16,
    parameter int OUT_WIDTH    = 16
) (
    input  logic [RESULT_WIDTH-1:0] value,
    output logic [OUT_WIDTH-1:0]    narrowed
);

    generate
        if (OUT_WIDTH == RESULT_WIDTH) begin : g_pass
            assign narrowed = value;
        end else begin : g_narrow
`ifdef STREAM_SAT_EN
            // The value fits when every dropped bit plus the new sign bit agree.
            logic [RESULT_WIDTH-OUT_WIDTH:0] upper;
            logic                            fits;
            assign upper    = value[RESULT_WIDTH-1:OUT_WIDTH-1];
            assign fits     = (&upper) | ~(|upper);
            assign narrowed = fits ? value[OUT_WIDTH-1:0] :
                              value[RESULT_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                                      {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
            assign narrowed = value[OUT_WIDTH-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/systolic_result_streamer.sv
// Captures result_c on done_in and streams M*P elements row-major; first element one cycle after capture.
// out_valid/out_ready backpressure holds outputs; a done_in that cannot be captured sets sticky overrun. Option: STREAM_SAT_EN.
module systolic_result_streamer
    import systolic_pkg::*;
#(
    parameter int RESULT_WIDTH = RESULT_WIDTH_DEF,
    parameter int M            = M_DEF,
    parameter int P            = P_DEF,
    parameter int OUT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done_in,
    input  logic [M*P*RESULT_WIDTH-1:0]   result_c,
    output logic                          res_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [clog2(M)-1:0]           out_row,
    output logic [clog2(P)-1:0]           out_col,
    output logic                          out_last_row,
    output logic                          out_last,
    output logic                          busy,
    output logic                          overrun
);

    localparam int RW = clog2(M);
    localparam int CW = clog2(P);

    stream_state_t               state;
    logic [M*P*RESULT_WIDTH-1:0] cap_buf;
    logic                        hs;
    logic                        capture;
    logic [RW-1:0]               next_row;
    logic [CW-1:0]               next_col;
    logic [RESULT_WIDTH-1:0]     elem_sel;
    logic [OUT_WIDTH-1:0]        elem_narrow;

    assign hs        = out_valid & out_ready;
    assign res_ready = (state == IDLE) | (hs & out_last);
    assign capture   = done_in & res_ready;
    assign busy      = (state == STREAM);

    // The element presented next is either (0,0) of a fresh capture or the successor in the buffer.
    always_comb begin
        next_row = out_row;
        next_col = out_col + 1'b1;
        if (out_col == CW'(P - 1)) begin
            next_col = '0;
            next_row = out_row + 1'b1;
        end
        if (capture) begin
            elem_sel = result_c[RESULT_WIDTH-1:0];
        end else begin
            elem_sel = cap_buf[(int'(next_row) * P + int'(next_col)) * RESULT_WIDTH +: RESULT_WIDTH];
        end
    end

    systolic_result_narrow #(
        .RESULT_WIDTH(RESULT_WIDTH),
        .OUT_WIDTH   (OUT_WIDTH)
    ) u_narrow (
        .value   (elem_sel),
        .narrowed(elem_narrow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cap_buf      <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_row      <= '0;
            out_col      <= '0;
            out_last_row <= 1'b0;
            out_last     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (done_in && !res_ready) begin
                overrun <= 1'b1;
            end
            if (capture) begin
                cap_buf      <= result_c;
                state        <= STREAM;
                out_valid    <= 1'b1;
                out_data     <= elem_narrow;
                out_row      <= '0;
                out_col      <= '0;
                out_last_row <= (P == 1);
                out_last     <= (M == 1) && (P == 1);
            end else if (hs) begin
                if (out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end else begin
                    out_data     <= elem_narrow;
                    out_row      <= next_row;
                    out_col      <= next_col;
                    out_last_row <= (next_col == CW'(P - 1));
                    out_last     <= (next_row == RW'(M - 1)) && (next_col == CW'(P - 1));
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_result_streamer.sv
// Randomized and directed checks of the result streamer against a queue-based element model,
// plus a table of narrowing vectors on a small 2x2, 8-bit-output instance.
module tb_systolic_result_streamer;

    localparam int RWID = 16;
    localparam int M    = 8;
    localparam int P    = 8;
    localparam int MW   = M * P * RWID;

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           done_in;
    logic [MW-1:0]  result_c;
    logic           out_ready;
    logic           res_ready;
    logic           out_valid;
    logic [15:0]    out_data;
    logic [2:0]     out_row;
    logic [2:0]     out_col;
    logic           out_last_row;
    logic           out_last;
    logic           busy;
    logic           overrun;

    logic           n_done;
    logic [63:0]    n_result;
    logic           n_ready;
    logic           n_res_ready;
    logic           n_valid;
    logic [7:0]     n_data;
    logic [0:0]     n_row;
    logic [0:0]     n_col;
    logic           n_last_row;
    logic           n_last;
    logic           n_busy;
    logic           n_overrun;

    systolic_result_streamer #(.RESULT_WIDTH(RWID), .M(M), .P(P), .OUT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .done_in(done_in), .result_c(result_c), .res_ready(res_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
        .out_col(out_col), .out_last_row(out_last_row), .out_last(out_last), .busy(busy),
        .overrun(overrun)
    );

    systolic_result_streamer #(.RESULT_WIDTH(16), .M(2), .P(2), .OUT_WIDTH(8)) dut_narrow (
        .clk(clk), .rst(rst), .done_in(n_done), .result_c(n_result), .res_ready(n_res_ready),
        .out_valid(n_valid), .out_ready(n_ready), .out_data(n_data), .out_row(n_row),
        .out_col(n_col), .out_last_row(n_last_row), .out_last(n_last), .busy(n_busy),
        .overrun(n_overrun)
    );

    typedef struct {
        logic [15:0] data;
        int          row;
        int          col;
    } elem_t;

    typedef struct {
        logic [15:0] in_val;
        logic [7:0]  exp_val;
    } nvec_t;

    elem_t q[$];
    logic  ovr_exp;
    int    vectors    = 0;
    int    miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("busy", busy, q.size() > 0);
        check("out_valid", out_valid, q.size() > 0);
        check("overrun", overrun, ovr_exp);
        if (q.size() > 0) begin
            check("out_data", out_data, q[0].data);
            check("out_row", out_row, q[0].row);
            check("out_col", out_col, q[0].col);
            check("out_last_row", out_last_row, q[0].col == P - 1);
            check("out_last", out_last, (q[0].row == M - 1) && (q[0].col == P - 1));
        end
    endtask

    // One clock of stimulus: the model consumes the front element on a handshake and
    // appends a whole matrix whenever a done pulse finds the stream empty or finishing.
    task automatic cycle(input logic d, input logic r, input logic [MW-1:0] mat);
        bit    hs;
        bit    last_hs;
        bit    cap;
        elem_t e;
        done_in   = d;
        out_ready = r;
        result_c  = mat;
        #1;
        hs      = (q.size() > 0) && r;
        last_hs = hs && (q.size() == 1);
        check("res_ready", res_ready, (q.size() == 0) || last_hs);
        @(posedge clk);
        cap = d && ((q.size() == 0) || last_hs);
        if (d && !cap) ovr_exp = 1'b1;
        if (hs) void'(q.pop_front());
        if (cap) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < P; j++) begin
                    e.data = mat[(i * P + j) * RWID +: RWID];
                    e.row  = i;
                    e.col  = j;
                    q.push_back(e);
                end
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        done_in   = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        q.delete();
        ovr_exp = 1'b0;
        check_outputs();
        check("rst_res_ready", res_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_col", out_col, 0);
        check("rst_out_last_row", out_last_row, 0);
        check("rst_out_last", out_last, 0);
        rst = 1'b0;
    endtask

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int k = 0; k < M * P; k++) m[k * RWID +: RWID] = 16'($urandom);
        return m;
    endfunction

    task automatic drain(input string name);
        int g;
        g = 0;
        while (q.size() > 0 && g < 2000) begin
            cycle(1'b0, 1'b1, rand_mat());
            g++;
        end
        check(name, q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [MW-1:0] m;
        nvec_t         tbl[8];
        int            g;

`ifdef STREAM_SAT_EN
        tbl[0] = '{16'h0123, 8'h7F};
        tbl[1] = '{16'hFF38, 8'h80};
        tbl[2] = '{16'h007F, 8'h7F};
        tbl[3] = '{16'hFF80, 8'h80};
        tbl[4] = '{16'h0080, 8'h7F};
        tbl[5] = '{16'hFF7F, 8'h80};
        tbl[6] = '{16'h0000, 8'h00};
        tbl[7] = '{16'hFFFF, 8'hFF};
`else
        tbl[0] = '{16'h0123, 8'h23};
        tbl[1] = '{16'hFF38, 8'h38};
        tbl[2] = '{16'h007F, 8'h7F};
        tbl[3] = '{16'hFF80, 8'h80};
        tbl[4] = '{16'h0080, 8'h80};
        tbl[5] = '{16'hFF7F, 8'h7F};
        tbl[6] = '{16'h0000, 8'h00};
        tbl[7] = '{16'hFFFF, 8'hFF};
`endif

        rst       = 1'b1;
        done_in   = 1'b0;
        out_ready = 1'b1;
        result_c  = '0;
        n_done    = 1'b0;
        n_ready   = 1'b1;
        n_result  = '0;
        ovr_exp   = 1'b0;

        // Reset, then idle cycles after release.
        do_reset(3);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // C[i][j] = i*8+j at full rate; result_c is scrambled while streaming.
        for (int k = 0; k < M * P; k++) m[k * RWID +: RWID] = 16'(k);
        cycle(1'b1, 1'b1, m);
        for (int k = 0; k < M * P; k++) cycle(1'b0, 1'b1, rand_mat());
        check("ident_idle", busy, 0);

        // Random 50% backpressure.
        cycle(1'b1, 1'b0, rand_mat());
        g = 0;
        while (q.size() > 0 && g < 2000) begin
            cycle(1'b0, 1'($urandom % 2), rand_mat());
            g++;
        end
        check("stall_drain", q.size(), 0);

        // Second done at element 10 is dropped and flagged.
        do_reset(1);
        cycle(1'b1, 1'b1, rand_mat());
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, rand_mat());
        check("elem10_col", out_col, 2);
        cycle(1'b1, 1'b1, rand_mat());
        check("overrun_set", overrun, 1);
        drain("overrun_drain");
        check("overrun_sticky", overrun, 1);

        // Done on the final handshake: back-to-back matrices, no overrun.
        do_reset(1);
        cycle(1'b1, 1'b1, rand_mat());
        for (int k = 0; k < M * P - 1; k++) cycle(1'b0, 1'b1, rand_mat());
        check("at_last", out_last, 1);
        cycle(1'b1, 1'b1, rand_mat());
        check("no_bubble_valid", out_valid, 1);
        check("restart_row", out_row, 0);
        check("restart_col", out_col, 0);
        check("no_overrun", overrun, 0);
        drain("b2b_drain");

        // Reset at element 20, then a fresh capture restarts at (0,0).
        cycle(1'b1, 1'b1, rand_mat());
        for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, rand_mat());
        do_reset(1);
        cycle(1'b1, 1'b1, rand_mat());
        check("fresh_row", out_row, 0);
        check("fresh_col", out_col, 0);
        drain("fresh_drain");

        // Mixed random done pulses and backpressure.
        do_reset(1);
        for (int k = 0; k < 400; k++) cycle(1'($urandom % 8 == 0), 1'($urandom % 2), rand_mat());
        drain("random_drain");

        // Narrowing table on the 2x2 instance.
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 4; k++) n_result[k * 16 +: 16] = tbl[b * 4 + k].in_val;
            n_done = 1'b1;
            @(posedge clk);
            #1;
            n_done   = 1'b0;
            n_result = '0;
            for (int k = 0; k < 4; k++) begin
                check("narrow_valid", n_valid, 1);
                check("narrow_data", n_data, tbl[b * 4 + k].exp_val);
                @(posedge clk);
                #1;
            end
            check("narrow_idle", n_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
